rst_sequencer: RTL and testbench

- Sits directly downstream of the reset synchroniser.
- Consumes the synchronised chip reset (inverted to active-high) and releases NumStages per-domain active-low resets in a fixed order.
- Waits a programmable delay plus a per-domain ready acknowledge between releases.
- Also supports a software-requested warm reset: the domains are re-asserted in reverse order, then the release sequence runs again.

---
 rtl/rst_sequencer_pkg.sv | 14 +
 rtl/rst_seq_delay_cnt.sv | 27 ++
 rtl/rst_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared types and defaults for the reset sequencer.
package rst_sequencer_pkg;

  typedef enum logic [2:0] {
    RST,
    DELAY,
    WAIT_ACK,
    RUN,
    ASSERT
  } state_e;

  localparam int unsigned DefaultStageDelay = 16;

endpackage

// File: rtl/rst_seq_delay_cnt.sv
// Free-running delay/timeout counter with synchronous clear and terminal compare.
module rst_seq_delay_cnt #(
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] term_i,
  output logic                hit_o
);

  logic [CntWidth-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + CntWidth'(1);
    end
  end

  assign hit_o = (cnt == term_i);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered per-domain reset release with ack handshake and warm-reset re-sequencing.
// Optional ack timeout enabled by defining RST_SEQUENCER_TIMEOUT_EN.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned NumStages     = 4,
  parameter int unsigned StageDelay    = DefaultStageDelay,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 sw_rst_req_i,
  input  logic [NumStages-1:0] stage_ack_i,
  output logic [NumStages-1:0] rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o
);

  localparam int unsigned         IdxW      = $clog2(NumStages);
  localparam logic [IdxW-1:0]     LastIdx   = IdxW'(NumStages - 1);
  localparam logic [CntWidth-1:0] DelayTerm = CntWidth'(StageDelay - 1);
  localparam bit                  OneCycle  = (StageDelay == 1);

  if (NumStages < 2) begin : g_err_stages
    $error("rst_sequencer: NumStages must be >= 2");
  end
  if (StageDelay < 1) begin : g_err_delay
    $error("rst_sequencer: StageDelay must be >= 1");
  end
  if (longint'(StageDelay) >= (longint'(1) << CntWidth)) begin : g_err_delay_width
    $error("rst_sequencer: StageDelay does not fit in CntWidth");
  end
  if (TimeoutCycles < 1) begin : g_err_timeout
    $error("rst_sequencer: TimeoutCycles must be >= 1");
  end

  state_e                state;
  logic [IdxW-1:0]       idx;
  logic [NumStages-1:0]  rst_q;
  logic                  sw_q;
  logic                  sw_edge;
  logic                  ack;
  logic                  ack_ok;
  logic                  tmo_fire;
  logic                  cnt_hit;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [CntWidth-1:0]   cnt_term;

  assign sw_edge = sw_rst_req_i & ~sw_q;
  assign ack     = stage_ack_i[idx];

`ifdef RST_SEQUENCER_TIMEOUT_EN
  localparam logic [CntWidth-1:0] TimeoutTerm = CntWidth'(TimeoutCycles - 1);

  if (longint'(TimeoutCycles) >= (longint'(1) << CntWidth)) begin : g_err_timeout_width
    $error("rst_sequencer: TimeoutCycles does not fit in CntWidth");
  end

  assign cnt_term = (state == WAIT_ACK) ? TimeoutTerm : DelayTerm;
  assign tmo_fire = (state == WAIT_ACK) & ~ack & cnt_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_o <= 1'b0;
    end else if (tmo_fire) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign cnt_term  = DelayTerm;
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign ack_ok = ack | tmo_fire;

  // The RST cycle counts toward stage 0's delay, so stage k releases after
  // edge (k+1)*StageDelay+k counted from the first edge out of reset.
  always_comb begin
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state)
      RST: begin
        cnt_clr = OneCycle;
        cnt_en  = 1'b1;
      end
      DELAY: begin
        cnt_clr = cnt_hit;
        cnt_en  = ~cnt_hit;
      end
`ifdef RST_SEQUENCER_TIMEOUT_EN
      WAIT_ACK: begin
        cnt_clr = ack_ok;
        cnt_en  = ~ack_ok;
      end
`endif
      default: ;
    endcase
  end

  rst_seq_delay_cnt #(
    .CntWidth(CntWidth)
  ) u_delay_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .term_i(cnt_term),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= RST;
      idx    <= '0;
      sw_q   <= 1'b0;
      rst_q  <= '0;
      busy_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      sw_q <= sw_rst_req_i;
      case (state)
        RST: begin
          idx   <= '0;
          state <= DELAY;
        end
        DELAY: begin
          if (cnt_hit) begin
            rst_q[idx] <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_ok) begin
            if (idx == LastIdx) begin
              state  <= RUN;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx   <= idx + IdxW'(1);
              state <= DELAY;
            end
          end
        end
        RUN: begin
          if (sw_edge) begin
            state  <= ASSERT;
            idx    <= LastIdx;
            busy_o <= 1'b1;
            done_o <= 1'b0;
          end
        end
        ASSERT: begin
          rst_q[idx] <= 1'b0;
          if (idx == '0) begin
            state <= DELAY;
          end else begin
            idx <= idx - IdxW'(1);
          end
        end
        default: state <= RST;
      endcase
    end
  end

  assign rst_no = test_mode_i ? {NumStages{~rst_i}} : rst_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer (NumStages=4, StageDelay=16).
module tb_rst_sequencer;

`ifdef RST_SEQUENCER_TIMEOUT_EN
  localparam int TO = 32;
`else
  localparam int TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       test_mode_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic [3:0] stage_ack_i = 4'hF;
  logic [3:0] rst_no;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         at;
    logic [3:0] rst;
    logic       done;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  rst_sequencer #(
    .NumStages    (4),
    .StageDelay   (16),
    .CntWidth     (8),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .test_mode_i (test_mode_i),
    .sw_rst_req_i(sw_rst_req_i),
    .stage_ack_i (stage_ack_i),
    .rst_no      (rst_no),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Domain ordering invariant: a released domain implies all lower ones released.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (rst_no[j] === 1'b1 && rst_no[j-1] !== 1'b1) begin
          errors++;
          $display("FAIL ordering t=%0t: rst_no=%b has bit %0d set without bit %0d", $time, rst_no, j, j - 1);
        end
      end
    end
  end

  function automatic void push(int at, logic [3:0] r, logic d, logic t);
    exp_t e;
    e.at = at; e.rst = r; e.done = d; e.tmo = t;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1;
    checks++;
    if (rst_no !== 4'b0000 || busy_o !== 1'b1 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rst_no=%b busy=%b done=%b tmo=%b, expected 0000 1 0 0", rst_no, busy_o, done_o, timeout_o);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rst_no !== 4'b0000 || busy_o !== 1'b1 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: rst_no=%b busy=%b done=%b tmo=%b, expected 0000 1 0 0", i, rst_no, busy_o, done_o, timeout_o);
      end
    end
  endtask

  task automatic test_power_on();
    sb.delete();
    push(16, 4'b0001, 1'b0, 1'b0);
    push(33, 4'b0011, 1'b0, 1'b0);
    push(50, 4'b0111, 1'b0, 1'b0);
    push(67, 4'b1111, 1'b0, 1'b0);
    push(68, 4'b1111, 1'b1, 1'b0);
    cur = '{0, 4'b0000, 1'b0, 1'b0};
    rst_i = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == n) cur = sb.pop_front();
      checks++;
      if (rst_no !== cur.rst || done_o !== cur.done || busy_o !== ~cur.done || timeout_o !== cur.tmo) begin
        errors++;
        $display("FAIL power_on edge %0d: rst_no=%b done=%b busy=%b tmo=%b, expected %b %b %b %b", n, rst_no, done_o, busy_o, timeout_o, cur.rst, cur.done, ~cur.done, cur.tmo);
      end
    end
  endtask

  task automatic test_warm_reset(input bit hold);
    int len;
    len = hold ? 230 : 90;
    sb.delete();
    push(1, 4'b1111, 1'b0, 1'b0);
    push(2, 4'b0111, 1'b0, 1'b0);
    push(3, 4'b0011, 1'b0, 1'b0);
    push(4, 4'b0001, 1'b0, 1'b0);
    push(5, 4'b0000, 1'b0, 1'b0);
    push(21, 4'b0001, 1'b0, 1'b0);
    push(38, 4'b0011, 1'b0, 1'b0);
    push(55, 4'b0111, 1'b0, 1'b0);
    push(72, 4'b1111, 1'b0, 1'b0);
    push(73, 4'b1111, 1'b1, 1'b0);
    cur = '{0, 4'b1111, 1'b1, 1'b0};
    sw_rst_req_i = 1'b1;
    for (int n = 1; n <= len; n++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == n) cur = sb.pop_front();
      checks++;
      if (rst_no !== cur.rst || done_o !== cur.done || busy_o !== ~cur.done || timeout_o !== cur.tmo) begin
        errors++;
        $display("FAIL warm_reset(hold=%0d) edge %0d: rst_no=%b done=%b busy=%b tmo=%b, expected %b %b %b %b", hold, n, rst_no, done_o, busy_o, timeout_o, cur.rst, cur.done, ~cur.done, cur.tmo);
      end
      if ((!hold && n == 1) || (hold && n == 200)) sw_rst_req_i = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    test_reset();
    rst_i = 1'b0;
    for (int n = 1; n <= 40; n++) tick();
    checks++;
    if (rst_no !== 4'b0011) begin
      errors++;
      $display("FAIL mid_reset_pre: rst_no=%b, expected 0011", rst_no);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (rst_no !== 4'b0000 || busy_o !== 1'b1 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: rst_no=%b busy=%b done=%b tmo=%b, expected 0000 1 0 0", rst_no, busy_o, done_o, timeout_o);
    end
    test_reset();
    test_power_on();
  endtask

  task automatic test_test_mode();
    test_mode_i = 1'b1;
    #1;
    checks++;
    if (rst_no !== 4'b1111) begin
      errors++;
      $display("FAIL test_mode_run: rst_no=%b, expected 1111", rst_no);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (rst_no !== 4'b0000 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL test_mode_rst_high: rst_no=%b busy=%b done=%b, expected 0000 1 0", rst_no, busy_o, done_o);
    end
    for (int i = 0; i < 3; i++) tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (rst_no !== 4'b1111) begin
      errors++;
      $display("FAIL test_mode_rst_low: rst_no=%b, expected 1111", rst_no);
    end
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (rst_no !== 4'b1111 || busy_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL test_mode_seq edge %0d: rst_no=%b busy=%b done=%b, expected 1111 1 0", n, rst_no, busy_o, done_o);
      end
    end
    test_mode_i = 1'b0;
    #1;
    checks++;
    if (rst_no !== 4'b0011) begin
      errors++;
      $display("FAIL test_mode_exit: rst_no=%b, expected 0011 from running FSM", rst_no);
    end
  endtask

`ifdef RST_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    test_reset();
    stage_ack_i = 4'b1011;
    sb.delete();
    push(16, 4'b0001, 1'b0, 1'b0);
    push(33, 4'b0011, 1'b0, 1'b0);
    push(50, 4'b0111, 1'b0, 1'b0);
    push(82, 4'b0111, 1'b0, 1'b1);
    push(98, 4'b1111, 1'b0, 1'b1);
    push(99, 4'b1111, 1'b1, 1'b1);
    cur = '{0, 4'b0000, 1'b0, 1'b0};
    rst_i = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == n) cur = sb.pop_front();
      checks++;
      if (rst_no !== cur.rst || done_o !== cur.done || busy_o !== ~cur.done || timeout_o !== cur.tmo) begin
        errors++;
        $display("FAIL timeout edge %0d: rst_no=%b done=%b busy=%b tmo=%b, expected %b %b %b %b", n, rst_no, done_o, busy_o, timeout_o, cur.rst, cur.done, ~cur.done, cur.tmo);
      end
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout_o=%b, expected 0 under rst_i", timeout_o);
    end
    stage_ack_i = 4'hF;
  endtask
`else
  task automatic test_withheld_ack();
    test_reset();
    stage_ack_i = 4'b1101;
    sb.delete();
    push(16, 4'b0001, 1'b0, 1'b0);
    push(33, 4'b0011, 1'b0, 1'b0);
    push(117, 4'b0111, 1'b0, 1'b0);
    push(134, 4'b1111, 1'b0, 1'b0);
    push(135, 4'b1111, 1'b1, 1'b0);
    cur = '{0, 4'b0000, 1'b0, 1'b0};
    rst_i = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == n) cur = sb.pop_front();
      checks++;
      if (rst_no !== cur.rst || done_o !== cur.done || busy_o !== ~cur.done || timeout_o !== cur.tmo) begin
        errors++;
        $display("FAIL withheld_ack edge %0d: rst_no=%b done=%b busy=%b tmo=%b, expected %b %b %b %b", n, rst_no, done_o, busy_o, timeout_o, cur.rst, cur.done, ~cur.done, cur.tmo);
      end
      if (n == 100) stage_ack_i = 4'hF;
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_power_on();
    test_warm_reset(1'b0);
    test_warm_reset(1'b1);
    test_mid_reset();
    test_test_mode();
`ifdef RST_SEQUENCER_TIMEOUT_EN
    test_timeout();
`else
    test_withheld_ack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
